shadow_chain_tx: RTL and testbench

//  Source end of a shadow-capture scan chain: the per-chain transmitter that feeds one cin/cin_vld/cin_status

---
 rtl/shadow_chain_tx_if.sv | 25 ++
 rtl/shadow_chain_tx.sv | 116 +++++++++++
 tb/tb_shadow_chain_tx.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shadow_chain_tx_if.sv
// Handshake/bus bundle between a shadow-chain transmitter and its driver/arbiter.
// Signal suffixes are from the transmitter's point of view.
interface shadow_chain_tx_if #(
  parameter int WIDTH = 32
);
  logic             capture_i;
  logic [WIDTH-1:0] cap_data_i;
  logic             dump_cmd_i;
  logic             rearm_i;
  logic             chain_out_o;
  logic             chain_vld_o;
  logic             chain_status_o;
  logic             busy_o;
  logic             overflow_o;

  modport master (
    output capture_i, cap_data_i, dump_cmd_i, rearm_i,
    input  chain_out_o, chain_vld_o, chain_status_o, busy_o, overflow_o
  );

  modport slave (
    input  capture_i, cap_data_i, dump_cmd_i, rearm_i,
    output chain_out_o, chain_vld_o, chain_status_o, busy_o, overflow_o
  );
endinterface

// File: rtl/shadow_chain_tx.sv
// Shadow-capture chain transmitter: snapshots WIDTH bits on capture and shifts them
// out LSB first on arbiter grant, with optional idle gaps between bits.
module shadow_chain_tx #(
  parameter int WIDTH   = 32,
  parameter int BIT_GAP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  shadow_chain_tx_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   BitLimit = CW'(WIDTH);
  localparam logic [7:0]      GapLimit = 8'(BIT_GAP);

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] snap_q;
  logic [CW-1:0]    bitCnt_q;
  logic [7:0]       gapCnt_q;
  logic             chainOut_q;
  logic             chainVld_q;
  logic             status_q;
  logic             busy_q;
  logic             overflow_q;

  // The snapshot is consumed as a shift register, so the next bit is always snap_q[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      bitCnt_q   <= '0;
      gapCnt_q   <= '0;
      chainOut_q <= 1'b0;
      chainVld_q <= 1'b0;
      status_q   <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.rearm_i) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      bitCnt_q   <= '0;
      gapCnt_q   <= '0;
      chainOut_q <= 1'b0;
      chainVld_q <= 1'b0;
      status_q   <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      chainVld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.capture_i) begin
            snap_q  <= bus.cap_data_i;
            state_q <= LOADED;
          end else if (bus.dump_cmd_i) begin
            state_q  <= DONE;
            status_q <= 1'b1;
          end
        end
        LOADED: begin
          if (bus.capture_i) begin
            snap_q <= bus.cap_data_i;
          end else if (bus.dump_cmd_i) begin
            state_q    <= SHIFT;
            busy_q     <= 1'b1;
            chainOut_q <= snap_q[0];
            chainVld_q <= 1'b1;
            snap_q     <= snap_q >> 1;
            bitCnt_q   <= CW'(1);
            gapCnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (bus.capture_i) begin
            overflow_q <= 1'b1;
          end
          // Completion does not wait for a grant: no trailing gap follows the last bit.
          if (bitCnt_q == BitLimit) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            status_q <= 1'b1;
          end else if (bus.dump_cmd_i) begin
            if (gapCnt_q != GapLimit) begin
              gapCnt_q <= gapCnt_q + 8'd1;
            end else begin
              chainOut_q <= snap_q[0];
              chainVld_q <= 1'b1;
              snap_q     <= snap_q >> 1;
              bitCnt_q   <= bitCnt_q + 1'b1;
              gapCnt_q   <= '0;
            end
          end
        end
        DONE: begin
          if (bus.capture_i) begin
            overflow_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.chain_out_o    = chainOut_q;
  assign bus.chain_vld_o    = chainVld_q;
  assign bus.chain_status_o = status_q;
  assign bus.busy_o         = busy_q;
  assign bus.overflow_o     = overflow_q;

endmodule

// File: tb/tb_shadow_chain_tx.sv
// Scoreboard bench for shadow_chain_tx: three lanes (8b/gap0, 8b/gap2, 1b/gap3)
// share one stimulus stream; expected bits are queued at dump time and popped on chain_vld.
module tb_shadow_chain_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       capture;
  logic       dumpCmd;
  logic       rearm;
  logic [7:0] dataA;
  logic [7:0] dataB;
  int         cyc = 0;
  int         checkCount = 0;
  int         failCount = 0;

  typedef struct {
    logic b;
    int   when;
  } exp_t;

  exp_t expQ[3][$];
  exp_t monE;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shadow_chain_tx_if #(.WIDTH(8)) busA ();
  shadow_chain_tx_if #(.WIDTH(8)) busB ();
  shadow_chain_tx_if #(.WIDTH(1)) busC ();

  assign busA.capture_i  = capture;
  assign busA.cap_data_i = dataA;
  assign busA.dump_cmd_i = dumpCmd;
  assign busA.rearm_i    = rearm;
  assign busB.capture_i  = capture;
  assign busB.cap_data_i = dataB;
  assign busB.dump_cmd_i = dumpCmd;
  assign busB.rearm_i    = rearm;
  assign busC.capture_i  = capture;
  assign busC.cap_data_i = dataA[0];
  assign busC.dump_cmd_i = dumpCmd;
  assign busC.rearm_i    = rearm;

  shadow_chain_tx #(.WIDTH(8), .BIT_GAP(0)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  shadow_chain_tx #(.WIDTH(8), .BIT_GAP(2)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));
  shadow_chain_tx #(.WIDTH(1), .BIT_GAP(3)) dutC (.clk(clk), .rst_n(rst_n), .bus(busC));

  logic [2:0] outL, vldL, stL, busyL, ovL;
  assign outL  = {busC.chain_out_o,    busB.chain_out_o,    busA.chain_out_o};
  assign vldL  = {busC.chain_vld_o,    busB.chain_vld_o,    busA.chain_vld_o};
  assign stL   = {busC.chain_status_o, busB.chain_status_o, busA.chain_status_o};
  assign busyL = {busC.busy_o,         busB.busy_o,         busA.busy_o};
  assign ovL   = {busC.overflow_o,     busB.overflow_o,     busA.overflow_o};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cap, input logic dump, input logic rm);
    capture = cap;
    dumpCmd = dump;
    rearm   = rm;
    tick();
  endtask

  task automatic checkZero(input string tag);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s_out%0d", tag, i), 32'(outL[i]), 0);
      checkOutput($sformatf("%s_vld%0d", tag, i), 32'(vldL[i]), 0);
      checkOutput($sformatf("%s_status%0d", tag, i), 32'(stL[i]), 0);
      checkOutput($sformatf("%s_busy%0d", tag, i), 32'(busyL[i]), 0);
      checkOutput($sformatf("%s_ovf%0d", tag, i), 32'(ovL[i]), 0);
    end
  endtask

  task automatic checkLanes(input string tag, input logic [2:0] actual, input logic [2:0] expected);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s%0d", tag, i), 32'(actual[i]), 32'(expected[i]));
    end
  endtask

  // Dump started while LOADED during cycle t: bit k of lane A at t+1+k, lane B at t+1+3k, lane C at t+1.
  task automatic pushDump(input int t, input logic [7:0] da, input logic [7:0] db, input bit timed);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.b    = da[k];
      e.when = timed ? t + 1 + k : -1;
      expQ[0].push_back(e);
      e.b    = db[k];
      e.when = timed ? t + 1 + 3 * k : -1;
      expQ[1].push_back(e);
    end
    e.b    = da[0];
    e.when = timed ? t + 1 : -1;
    expQ[2].push_back(e);
  endtask

  task automatic checkQueuesEmpty(input string tag);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s_left%0d", tag, i), 32'(expQ[i].size()), 0);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vldL[i] === 1'b1) begin
        if (expQ[i].size() == 0) begin
          checkOutput($sformatf("lane%0d_unexpectedVld", i), 1, 0);
        end else begin
          monE = expQ[i].pop_front();
          checkOutput($sformatf("lane%0d_bit", i), 32'(outL[i]), 32'(monE.b));
          if (monE.when >= 0) begin
            checkOutput($sformatf("lane%0d_bitTime", i), 32'(cyc), 32'(monE.when));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    rst_n   = 1'b0;
    capture = 1'b0;
    dumpCmd = 1'b0;
    rearm   = 1'b0;
    dataA   = 8'h00;
    dataB   = 8'h00;
    tick();
    tick();
    checkZero("reset");
    rst_n = 1'b1;
    tick();

    // Uninterrupted dumps: A5 on the gap-0 lane, 81 on the gap-2 lane
    dataA = 8'hA5;
    dataB = 8'h81;
    applyStimulus(1'b1, 1'b0, 1'b0);
    t = cyc;
    pushDump(t, dataA, dataB, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkLanes("busyFirst", busyL, 3'b111);
    checkLanes("statusFirst", stL, 3'b000);
    for (int i = 2; i <= 26; i++) begin
      tick();
      if (i == 2) begin
        checkOutput("statusC_w1", 32'(stL[2]), 1);
        checkOutput("busyC_w1", 32'(busyL[2]), 0);
      end
      if (i == 8)  checkOutput("statusA_beforeEnd", 32'(stL[0]), 0);
      if (i == 9) begin
        checkOutput("statusA_end", 32'(stL[0]), 1);
        checkOutput("busyA_end", 32'(busyL[0]), 0);
      end
      if (i == 22) checkOutput("statusB_beforeEnd", 32'(stL[1]), 0);
      if (i == 23) begin
        checkOutput("statusB_end", 32'(stL[1]), 1);
        checkOutput("busyB_end", 32'(busyL[1]), 0);
      end
    end
    checkQueuesEmpty("dump1");

    // Capture while DONE is dropped and flagged
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkLanes("ovfDone", ovL, 3'b111);
    checkLanes("statusDone", stL, 3'b111);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkLanes("rearmStatus", stL, 3'b000);
    checkLanes("rearmOvf", ovL, 3'b000);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Pause after bit 3 of lane A for five cycles, then resume
    dataA = 8'h5C;
    dataB = 8'hC3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    t = cyc;
    pushDump(t, dataA, dataB, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("pauseVldA", 32'(vldL[0]), 0);
      checkOutput("pauseVldB", 32'(vldL[1]), 0);
      checkOutput("pauseBusyA", 32'(busyL[0]), 1);
      if (i < 4) tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    checkQueuesEmpty("pause");
    checkLanes("pauseStatus", stL, 3'b111);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Latest capture wins; capture during SHIFT overflows without touching the data
    dataA = 8'h11;
    dataB = 8'h11;
    applyStimulus(1'b1, 1'b0, 1'b0);
    dataA = 8'h22;
    dataB = 8'h22;
    applyStimulus(1'b1, 1'b0, 1'b0);
    t = cyc;
    pushDump(t, 8'h22, 8'h22, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkLanes("ovfBefore", ovL, 3'b000);
    dataA = 8'hFF;
    dataB = 8'hFF;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkLanes("ovfShift", ovL, 3'b111);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) tick();
    checkQueuesEmpty("overwrite");
    checkLanes("overwriteStatus", stL, 3'b111);

    // Empty dump from IDLE, then rearm
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkLanes("rearm2Status", stL, 3'b000);
    checkLanes("rearm2Ovf", ovL, 3'b000);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkLanes("emptyStatus", stL, 3'b111);
    checkLanes("emptyBusy", busyL, 3'b000);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkLanes("rearm3Status", stL, 3'b000);
    checkLanes("rearm3Ovf", ovL, 3'b000);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // rearm together with capture in LOADED leaves IDLE with no snapshot
    dataA = 8'hA5;
    dataB = 8'hA5;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkZero("rearmCapture");
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkLanes("noSnapStatus", stL, 3'b111);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a dump
    dataA = 8'hFF;
    dataB = 8'hFF;
    applyStimulus(1'b1, 1'b0, 1'b0);
    t = cyc;
    pushDump(t, dataA, dataB, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("rstMid");
    for (int i = 0; i < 3; i++) expQ[i].delete();
    dumpCmd = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checkZero("afterRst");
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkLanes("afterRstEmpty", stL, 3'b111);
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
